puf_host_seq: RTL
=================

Name: puf_host_seq

Overview:
- Host-side sequencer that drives the PUF register interface (control/address/data_in in, data_out/end_op back) from the initiator end.
- Accepts one generation request (BG, SD, cnfa, n_cmps, word count), then resets the PUF and loads its configuration word.
- Waits for end-of-operation, then fetches each 64-bit response word in address order and streams the words out over a valid/ready port.
- Sits between an internal requester (key-derivation or TRNG consumer) and the PUF interface, replacing software-driven register access.

Parameters:
- WIDTH, 64, bus and response-word width.
- TO_BITS, 24, width of the end_op timeout counter; timeout fires when the counter reaches all-ones.
- RD_LAT, 1, cycles from the read strobe to valid puf_data_out; legal range 1..3.

Ports:
- clk  in  1  system clock.
- i_rst  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_bg  in  1  BG configuration bit.
- req_sd  in  1  SD configuration bit.
- req_cnfa  in  2  cnfa configuration field.
- req_ncmps  in  13  number of comparisons.
- req_nwords_m1  in  8  response words to fetch, minus one (0 means 1 word, 255 means 256 words).
- m_data  out  WIDTH  response word.
- m_valid  out  1  m_data valid.
- m_ready  in  1  sink ready.
- m_last  out  1  marks the final word.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on timeout.
- busy  out  1  high whenever not in IDLE.
- puf_control  out  4  {read, load, rst_itf, rst}.
- puf_address  out  WIDTH  register address.
- puf_data_in  out  WIDTH  write data.
- puf_data_out  in  WIDTH  read data.
- puf_end_op  in  1  PUF end of operation.

Behaviour:
- All outputs are registered. While i_rst is low, every output is 0 and the state is IDLE.
- Configuration word CFG(str, a) = {38'b0, a[7:0], ncmps[12:0], cnfa[1:0], sd, bg, str}, built from fields latched at acceptance.
- IDLE: req_ready=1. When req_valid and req_ready are both high, latch all req_* fields, clear word index k and the timeout counter, and go to RST.
- RST: one cycle, puf_control=4'b0011. Go to CFG.
- CFG: one cycle, puf_control=4'b0100, puf_address=0, puf_data_in=CFG(1,0). Go to WAIT.
- WAIT: puf_control=0. The timeout counter increments every cycle.
  - If puf_end_op is sampled high, go to ADDR.
  - Else, if the counter is all-ones, go to FAIL.
  - If end_op and all-ones occur in the same cycle, end_op wins.
- ADDR: one cycle, load with puf_data_in=CFG(1,k). Go to RD.
- RD: puf_control=4'b1000, puf_address=0, held for RD_LAT cycles. On the last of those cycles, capture puf_data_out into m_data. Go to PUSH.
- PUSH: m_valid=1, and m_last=1 when k==nwords_m1. m_data is stable until the handshake.
  - On m_valid and m_ready both high, drop m_valid.
  - If the word was last, go to FIN; otherwise increment k and go to ADDR.
  - A stalled m_ready holds PUSH indefinitely; no timeout applies.
- FIN: one cycle, load CFG(0,0) to drop puf_str, and pulse done. Go to IDLE.
- FAIL: one cycle, puf_control=4'b0011, and pulse err. Go to IDLE. No words are emitted after a timeout.
- k is 8 bits and never wraps: for nwords_m1=255, the final word is k=255 and the sequence then goes to FIN.
- puf_control returns to 0 the cycle after every single-cycle strobe state. load and read are never both set.
- Asynchronous reset mid-operation aborts immediately with no done or err pulse. The first request after reset starts again at RST.
- req_* inputs are ignored outside IDLE.

Test Plan:
- Single word: req nwords_m1=0, bg=1, sd=0, cnfa=2, ncmps=100; end_op after 50 cycles; puf_data_out=64'hDEADBEEF_0BADF00D
  - -> exactly one m_valid beat with m_last=1 and that data.
  - -> CFG write data = {38'b0, 8'd0, 13'd100, 2'd2, 1'b0, 1'b1, 1'b1}.
  - -> done pulses once.
- Four words with m_ready toggled 1/0 each cycle; the model returns word = 64'hA0+addr
  - -> words A0..A3 in order, each held stable while stalled.
  - -> m_last only on A3.
  - -> puf_data_in[25:18] steps 0..3.
- Timeout with TO_BITS=6 and end_op never asserted
  - -> err pulses 63 cycles into WAIT.
  - -> RST control 4'b0011 is issued.
  - -> no m_valid; busy drops to 0 and req_ready returns to 1.
- end_op and timeout in the same cycle
  - -> no err; fetch proceeds normally.
- i_rst asserted during PUSH of word 2 of 4
  - -> all outputs 0 asynchronously, no done.
  - -> a new request afterwards starts with control 4'b0011.
- nwords_m1=255
  - -> 256 beats; the last has address 255 and m_last=1; k never wraps and the sequence then reaches FIN.

Source files
------------

// File: rtl/puf_host_seq.sv
// Host-side PUF sequencer: resets the PUF, writes its configuration word,
// waits for end-of-operation, then reads each response word in address order
// and streams it out over a valid/ready port.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. valid never depends on ready. Once valid is raised, it and
// its data stay unchanged until that transfer. req_valid/req_ready and
// m_valid/m_ready both follow this rule.
module puf_host_seq #(
    parameter int WIDTH   = 64,
    parameter int TO_BITS = 24,
    parameter int RD_LAT  = 1
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_bg,
    input  logic             req_sd,
    input  logic [1:0]       req_cnfa,
    input  logic [12:0]      req_ncmps,
    input  logic [7:0]       req_nwords_m1,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             done,
    output logic             err,
    output logic             busy,
    output logic [3:0]       puf_control,
    output logic [WIDTH-1:0] puf_address,
    output logic [WIDTH-1:0] puf_data_in,
    input  logic [WIDTH-1:0] puf_data_out,
    input  logic             puf_end_op,
    output logic [3:0]       state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_RST  = 4'd1,
        S_CFG  = 4'd2,
        S_WAIT = 4'd3,
        S_ADDR = 4'd4,
        S_RD   = 4'd5,
        S_PUSH = 4'd6,
        S_FIN  = 4'd7,
        S_FAIL = 4'd8
    } state_t;

    state_t             state, state_n;
    logic [7:0]         k, k_n;
    logic [TO_BITS-1:0] to_cnt, to_cnt_n;
    logic [1:0]         rd_cnt, rd_cnt_n;
    logic               accept, capture;

    // Request fields held for the whole operation.
    logic               bg_q, sd_q;
    logic [1:0]         cnfa_q;
    logic [12:0]        ncmps_q;
    logic [7:0]         nw_q;

    // Next values of the registered outputs, decoded from the next state.
    logic [3:0]         ctrl_n;
    logic [WIDTH-1:0]   data_in_n;
    logic               m_valid_n, m_last_n, done_n, err_n, ready_n;

    // Configuration word: {zeros, a, ncmps, cnfa, sd, bg, str}.
    function automatic logic [WIDTH-1:0] cfg_word(
        input logic str, input logic [7:0] a, input logic bg, input logic sd,
        input logic [1:0] cnfa, input logic [12:0] ncmps);
        logic [WIDTH-1:0] w;
        w        = '0;
        w[25:0]  = {a, ncmps, cnfa, sd, bg, str};
        return w;
    endfunction

    assign state_dbg = state;

    // Next-state logic, counters, and output decode from the next state.
    always_comb begin
        state_n  = state;
        k_n      = k;
        to_cnt_n = to_cnt;
        rd_cnt_n = rd_cnt;
        accept   = 1'b0;
        capture  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    accept   = 1'b1;
                    k_n      = 8'd0;
                    to_cnt_n = '0;
                    state_n  = S_RST;
                end
            end
            S_RST:  state_n = S_CFG;
            S_CFG:  state_n = S_WAIT;
            S_WAIT: begin
                to_cnt_n = to_cnt + TO_BITS'(1);
                // end_op has priority over a timeout landing in the same cycle.
                if (puf_end_op)      state_n = S_ADDR;
                else if (&to_cnt_n)  state_n = S_FAIL;
            end
            S_ADDR: begin
                rd_cnt_n = 2'd0;
                state_n  = S_RD;
            end
            S_RD: begin
                if (rd_cnt == 2'(RD_LAT - 1)) begin
                    capture = 1'b1;
                    state_n = S_PUSH;
                end else begin
                    rd_cnt_n = rd_cnt + 2'd1;
                end
            end
            S_PUSH: begin
                if (m_valid && m_ready) begin
                    if (k == nw_q) begin
                        state_n = S_FIN;
                    end else begin
                        k_n     = k + 8'd1;
                        state_n = S_ADDR;
                    end
                end
            end
            S_FIN:   state_n = S_IDLE;
            S_FAIL:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        ctrl_n    = 4'b0000;
        data_in_n = '0;
        m_valid_n = 1'b0;
        m_last_n  = 1'b0;
        done_n    = 1'b0;
        err_n     = 1'b0;
        ready_n   = (state_n == S_IDLE);
        case (state_n)
            S_RST:  ctrl_n = 4'b0011;
            S_CFG: begin
                ctrl_n    = 4'b0100;
                data_in_n = cfg_word(1'b1, 8'd0, bg_q, sd_q, cnfa_q, ncmps_q);
            end
            S_ADDR: begin
                ctrl_n    = 4'b0100;
                data_in_n = cfg_word(1'b1, k_n, bg_q, sd_q, cnfa_q, ncmps_q);
            end
            S_RD:   ctrl_n = 4'b1000;
            S_PUSH: begin
                m_valid_n = 1'b1;
                m_last_n  = (k_n == nw_q);
            end
            S_FIN: begin
                ctrl_n    = 4'b0100;
                data_in_n = cfg_word(1'b0, 8'd0, bg_q, sd_q, cnfa_q, ncmps_q);
                done_n    = 1'b1;
            end
            S_FAIL: begin
                ctrl_n = 4'b0011;
                err_n  = 1'b1;
            end
            default: ;
        endcase
    end

    // State, counters, latched request and all registered outputs.
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= S_IDLE;
            k           <= 8'd0;
            to_cnt      <= '0;
            rd_cnt      <= 2'd0;
            bg_q        <= 1'b0;
            sd_q        <= 1'b0;
            cnfa_q      <= 2'd0;
            ncmps_q     <= 13'd0;
            nw_q        <= 8'd0;
            m_data      <= '0;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
            req_ready   <= 1'b0;
            puf_control <= 4'b0000;
            puf_address <= '0;
            puf_data_in <= '0;
        end else begin
            state       <= state_n;
            k           <= k_n;
            to_cnt      <= to_cnt_n;
            rd_cnt      <= rd_cnt_n;
            if (accept) begin
                bg_q    <= req_bg;
                sd_q    <= req_sd;
                cnfa_q  <= req_cnfa;
                ncmps_q <= req_ncmps;
                nw_q    <= req_nwords_m1;
            end
            if (capture) m_data <= puf_data_out;
            m_valid     <= m_valid_n;
            m_last      <= m_last_n;
            done        <= done_n;
            err         <= err_n;
            busy        <= !ready_n;
            req_ready   <= ready_n;
            puf_control <= ctrl_n;
            puf_address <= '0;
            puf_data_in <= data_in_n;
        end
    end

endmodule
